sram_1024x64_arbiter: RTL
=========================

Name: sram_1024x64_arbiter

Overview:
- Shares one 1024x64 single-port SRAM between N requesters, e.g. the octree traversal engine and the host in/out DMA.
- Round-robin arbitration with per-requester valid/ready request channels.
- Optional lock holds the grant across multi-beat bursts.
- Read data returns a fixed latency later, tagged to the issuing requester.
- Sits directly in front of the sram_1024x64 instance for local_mem / in_out_mem.

Parameters:
- N, 2, number of requesters (2..4).
- AW, 10, SRAM address width.
- DW, 64, SRAM data and bit-mask width.

Ports:
- i_clk  in  1  clock; all logic on the rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_req_valid  in  N  per-requester request valid.
- o_req_ready  out  N  per-requester accept; at most one bit set per cycle.
- i_req_wen  in  N  1 = write, 0 = read.
- i_req_lock  in  N  1 = keep grant after this beat.
- i_req_addr  in  N*AW  flattened addresses; requester k at [k*AW +: AW].
- i_req_wdata  in  N*DW  flattened write data.
- i_req_mask  in  N*DW  flattened bit masks; 1 = write bit.
- o_rsp_valid  out  N  read data valid for requester k.
- o_rsp_rdata  out  DW  read data, shared by all requesters.
- o_sram_cen  out  1  SRAM enable, active-high.
- o_sram_wen  out  1  SRAM write enable, active-high.
- o_sram_addr  out  AW  SRAM address.
- o_sram_wdata  out  DW  SRAM write data.
- o_sram_bit_mask  out  DW  SRAM write mask.
- i_sram_rdata  in  DW  SRAM read data; valid one cycle after a read is issued.

Behaviour:
- Reset (i_rst=1 at a clock edge):
  - rr_ptr=0, state=ARB, lock_owner=0.
  - Read-response pipe cleared.
  - Next cycle: all o_req_ready=0, o_rsp_valid=0, o_sram_cen=0, o_sram_wen=0, addr/wdata/mask=0.
  - Reset mid-burst or mid-read drops the lock and any pending response.
- Accepted beat: i_req_valid[k] & o_req_ready[k].
- o_req_ready is combinational from registered state and current i_req_valid. There is no dependency on o_req_ready, so no loop.
- SRAM drive:
  - Beat accepted this cycle: o_sram_* driven combinationally from the granted requester; o_sram_cen=1, o_sram_wen=i_req_wen[k].
  - Read beat: o_sram_bit_mask=0.
  - No beat: o_sram_cen=0, o_sram_wen=0, other SRAM outputs 0.
- State ARB:
  - Grant goes to the first valid requester searching from rr_ptr upward, modulo N.
  - No valid requester: no grant, state holds.
  - Accepted beat with lock=0: rr_ptr <= (k+1) mod N; stay in ARB.
  - Accepted beat with lock=1: lock_owner <= k; state <= LOCKED. rr_ptr is unchanged.
- State LOCKED:
  - o_req_ready[lock_owner] = i_req_valid[lock_owner]; all other ready=0.
  - Owner may drop valid for any number of cycles; the grant is held and there is no timeout.
  - Accepted beat with lock=1: stay in LOCKED.
  - Accepted beat with lock=0: rr_ptr <= (lock_owner+1) mod N; state <= ARB. New arbitration happens the following cycle.
- Read response:
  - Every accepted read sets o_rsp_valid[k]=1 exactly one cycle later; o_rsp_rdata = i_sram_rdata (pass-through).
  - Back-to-back reads give back-to-back responses in issue order.
  - Writes produce no response.
  - o_rsp_rdata is don't-care when no o_rsp_valid bit is set; the bench must not check it then.
- Throughput: one access per cycle, no bubbles on grant switch.
- Simultaneous valid on all requesters: strict rotation, each served once per N accepted unlocked beats.
- Address: full 0..2^AW-1 passed unchanged; no wrap logic.

Optional Feature:
- Macro: SRAM_ARB_RSP_REG_EN.
- Defined:
  - i_sram_rdata is captured in a DW-bit register.
  - o_rsp_valid and o_rsp_rdata appear two cycles after the accepted read, both registered.
  - The register is reset to 0.
- Undefined: one-cycle latency with rdata pass-through, as specified above.

Test Plan:
- Reset, then idle: o_req_ready=0, o_sram_cen=0, o_rsp_valid=0 for 5 cycles.
- Req0 writes addr 0x005, wdata 0xDEADBEEF_01234567, mask all-ones; then req0 reads 0x005 -> o_rsp_valid=2'b01 one cycle after the read, rdata=0xDEADBEEF_01234567.
- Both requesters valid continuously, lock=0, for 6 cycles from reset -> grant sequence 0,1,0,1,0,1; each read response tagged to the correct requester.
- Req1 holds lock=1 for 4 beats (addr 0x3FC..0x3FF, last beat lock=0) while req0 stays valid -> req0 ready=0 for those 4 cycles; req0 granted the following cycle.
- Partial write: mask 0x00000000_FFFFFFFF, wdata all-ones over 0x0 contents -> read back 0x00000000_FFFFFFFF.
- i_rst asserted in the cycle after a read issue while LOCKED -> o_rsp_valid=0 next cycle; state ARB, rr_ptr=0; req1 not favoured.
- With SRAM_ARB_RSP_REG_EN defined, repeat the second scenario -> response two cycles after issue.

Source files
------------

// File: rtl/sram_1024x64_arbiter_if.sv
// Request/response and SRAM-side bus of the shared 1024x64 SRAM arbiter.
// The slave modport is the arbiter; the master modport is the requesters plus the SRAM.
interface sram_1024x64_arbiter_if #(
    parameter int N  = 2,
    parameter int AW = 10,
    parameter int DW = 64
);
    logic [N-1:0]    i_req_valid;
    logic [N-1:0]    o_req_ready;
    logic [N-1:0]    i_req_wen;
    logic [N-1:0]    i_req_lock;
    logic [N*AW-1:0] i_req_addr;
    logic [N*DW-1:0] i_req_wdata;
    logic [N*DW-1:0] i_req_mask;
    logic [N-1:0]    o_rsp_valid;
    logic [DW-1:0]   o_rsp_rdata;
    logic            o_sram_cen;
    logic            o_sram_wen;
    logic [AW-1:0]   o_sram_addr;
    logic [DW-1:0]   o_sram_wdata;
    logic [DW-1:0]   o_sram_bit_mask;
    logic [DW-1:0]   i_sram_rdata;

    modport slave (
        input  i_req_valid, i_req_wen, i_req_lock, i_req_addr, i_req_wdata, i_req_mask,
        input  i_sram_rdata,
        output o_req_ready, o_rsp_valid, o_rsp_rdata,
        output o_sram_cen, o_sram_wen, o_sram_addr, o_sram_wdata, o_sram_bit_mask
    );

    modport master (
        output i_req_valid, i_req_wen, i_req_lock, i_req_addr, i_req_wdata, i_req_mask,
        output i_sram_rdata,
        input  o_req_ready, o_rsp_valid, o_rsp_rdata,
        input  o_sram_cen, o_sram_wen, o_sram_addr, o_sram_wdata, o_sram_bit_mask
    );
endinterface

// File: rtl/sram_1024x64_arbiter.sv
// Round-robin arbiter sharing one single-port 1024x64 SRAM between N requesters, with burst lock.
// Define SRAM_ARB_RSP_REG_EN to register read data and add one cycle of response latency.
module sram_1024x64_arbiter #(
    parameter int N  = 2,
    parameter int AW = 10,
    parameter int DW = 64
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    sram_1024x64_arbiter_if.slave   bus
);
    localparam int PW = $clog2(N);

    typedef enum logic {
        ST_ARB,
        ST_LOCKED
    } state_t;

    state_t          state_reg, state_next;
    logic [PW-1:0]   rr_ptr_reg, rr_ptr_next;
    logic [PW-1:0]   lock_owner_reg, lock_owner_next;
    logic [N-1:0]    rsp_tag_reg;

    logic [PW-1:0]   rot_idx [N];
    logic [AW-1:0]   req_addr [N];
    logic [DW-1:0]   req_wdata [N];
    logic [DW-1:0]   req_mask [N];
    logic            grant_any;
    logic [PW-1:0]   grant_idx;
    logic [N-1:0]    ready_vec;
    logic [N-1:0]    rd_accept;

    function automatic logic [PW-1:0] next_idx(input logic [PW-1:0] idx);
        return (idx == PW'(N - 1)) ? '0 : idx + 1'b1;
    endfunction

    // rot_idx[i] is the requester searched i-th, starting at rr_ptr and wrapping at N
    for (genvar gi = 0; gi < N; gi++) begin : g_req
        logic [PW:0] rot_sum;
        assign rot_sum       = {1'b0, rr_ptr_reg} + (PW+1)'(gi);
        assign rot_idx[gi]   = (rot_sum >= (PW+1)'(N)) ? PW'(rot_sum - (PW+1)'(N)) : PW'(rot_sum);
        assign req_addr[gi]  = bus.i_req_addr[gi*AW +: AW];
        assign req_wdata[gi] = bus.i_req_wdata[gi*DW +: DW];
        assign req_mask[gi]  = bus.i_req_mask[gi*DW +: DW];
        assign ready_vec[gi] = grant_any && (grant_idx == PW'(gi));
    end

    // Reset blocks any grant so no SRAM access slips through the reset cycle
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        if (!i_rst) begin
            if (state_reg == ST_LOCKED) begin
                grant_any = bus.i_req_valid[lock_owner_reg];
                grant_idx = lock_owner_reg;
            end else begin
                for (int i = N - 1; i >= 0; i--) begin
                    if (bus.i_req_valid[rot_idx[i]]) begin
                        grant_any = 1'b1;
                        grant_idx = rot_idx[i];
                    end
                end
            end
        end
    end

    assign bus.o_req_ready = ready_vec;
    assign rd_accept       = ready_vec & ~bus.i_req_wen;

    always_comb begin
        bus.o_sram_cen      = 1'b0;
        bus.o_sram_wen      = 1'b0;
        bus.o_sram_addr     = '0;
        bus.o_sram_wdata    = '0;
        bus.o_sram_bit_mask = '0;
        if (grant_any) begin
            bus.o_sram_cen      = 1'b1;
            bus.o_sram_wen      = bus.i_req_wen[grant_idx];
            bus.o_sram_addr     = req_addr[grant_idx];
            bus.o_sram_wdata    = req_wdata[grant_idx];
            bus.o_sram_bit_mask = bus.i_req_wen[grant_idx] ? req_mask[grant_idx] : '0;
        end
    end

    always_comb begin
        state_next      = state_reg;
        rr_ptr_next     = rr_ptr_reg;
        lock_owner_next = lock_owner_reg;
        if (state_reg == ST_ARB) begin
            if (grant_any) begin
                if (bus.i_req_lock[grant_idx]) begin
                    lock_owner_next = grant_idx;
                    state_next      = ST_LOCKED;
                end else begin
                    rr_ptr_next = next_idx(grant_idx);
                end
            end
        end else begin
            if (grant_any && !bus.i_req_lock[lock_owner_reg]) begin
                rr_ptr_next = next_idx(lock_owner_reg);
                state_next  = ST_ARB;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg      <= ST_ARB;
            rr_ptr_reg     <= '0;
            lock_owner_reg <= '0;
            rsp_tag_reg    <= '0;
        end else begin
            state_reg      <= state_next;
            rr_ptr_reg     <= rr_ptr_next;
            lock_owner_reg <= lock_owner_next;
            rsp_tag_reg    <= rd_accept;
        end
    end

`ifdef SRAM_ARB_RSP_REG_EN
    logic [N-1:0]  rsp_valid_reg;
    logic [DW-1:0] rsp_rdata_reg;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rsp_valid_reg <= '0;
            rsp_rdata_reg <= '0;
        end else begin
            rsp_valid_reg <= rsp_tag_reg;
            rsp_rdata_reg <= bus.i_sram_rdata;
        end
    end

    assign bus.o_rsp_valid = rsp_valid_reg;
    assign bus.o_rsp_rdata = rsp_rdata_reg;
`else
    assign bus.o_rsp_valid = rsp_tag_reg;
    assign bus.o_rsp_rdata = bus.i_sram_rdata;
`endif

endmodule
